// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS instruction-memory boot loader.
package mips_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  // sll $0,$0,0
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word packer: lane counter plus staging register.
module imem_byte_packer
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_byte_en,
  input  logic [7:0]            i_byte,
  output logic                  o_word_valid_c,
  output logic [DATA_WIDTH-1:0] o_word_c
);

  localparam int unsigned BPW    = DATA_WIDTH / 8;
  localparam int unsigned LANE_W = (clog2(BPW) > 0) ? clog2(BPW) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BPW - 1);

  logic [LANE_W-1:0]     r_lane;
  logic [DATA_WIDTH-1:0] r_stage;
  logic                  w_last;

  assign w_last         = (r_lane == LAST_LANE);
  assign o_word_valid_c = i_byte_en && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane  <= '0;
      r_stage <= '0;
    end else if (i_clear) begin
      r_lane <= '0;
    end else if (i_byte_en) begin
      r_stage[{r_lane, 3'b000} +: 8] <= i_byte;
      r_lane <= w_last ? '0 : r_lane + 1'b1;
    end
  end

  // Current byte bypasses the staging register so the word is complete on its own edge.
  always_comb begin
    o_word_c = r_stage;
    o_word_c[{r_lane, 3'b000} +: 8] = i_byte;
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction memory with a byte-stream boot loader and a combinational fetch port.
module imem_boot_loader
  import mips_mem_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DEPTH_WORDS = 1024,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD    = DATA_WIDTH'(MIPS_NOP)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_data,
  output logic                  ld_ready,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  misaligned,
  output logic                  out_of_range,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err,
  output logic [15:0]           words_loaded
);

  localparam int unsigned IDX_W     = clog2(DEPTH_WORDS);
  localparam logic [16:0] DEPTH_CMP = 17'(DEPTH_WORDS);

  loader_state_e r_state;
  loader_state_e w_state_nxt;

  logic [15:0]           r_count;
  logic [15:0]           r_words_loaded;
  logic [IDX_W-1:0]      r_wr_idx;
  logic                  r_ld_ready;
  logic                  r_cpu_hold;
  logic                  r_load_done;
  logic                  r_load_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic                  w_accept;
  logic                  w_clear;
  logic                  w_byte_en;
  logic                  w_mem_we;
  logic                  w_word_valid;
  logic [DATA_WIDTH-1:0] w_word;
  logic [15:0]           w_count_full;
  logic [15:0]           w_words_inc;
  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic [IDX_W-1:0]      w_rd_idx;

  assign w_accept     = ld_valid && r_ld_ready;
  assign w_byte_en    = w_accept && (r_state == ST_DATA);
  assign w_count_full = {ld_data, r_count[7:0]};
  assign w_words_inc  = r_words_loaded + 16'd1;

  imem_byte_packer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_packer (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (w_clear),
    .i_byte_en     (w_byte_en),
    .i_byte        (ld_data),
    .o_word_valid_c(w_word_valid),
    .o_word_c      (w_word)
  );

  // Loader next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_mem_we    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (load_start) begin
          w_state_nxt = ST_HDR0;
          w_clear     = 1'b1;
        end
      end
      ST_HDR0: begin
        if (w_accept) w_state_nxt = ST_HDR1;
      end
      ST_HDR1: begin
        if (w_accept) begin
          if (w_count_full == 16'd0)                  w_state_nxt = ST_DONE;
          else if ({1'b0, w_count_full} > DEPTH_CMP)  w_state_nxt = ST_ERR;
          else                                        w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_word_valid) begin
          w_mem_we = 1'b1;
          if (w_words_inc == r_count) w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register with status flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ld_ready  <= 1'b0;
      r_cpu_hold  <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ld_ready  <= (w_state_nxt == ST_HDR0) || (w_state_nxt == ST_HDR1) ||
                     (w_state_nxt == ST_DATA);
      r_cpu_hold  <= (w_state_nxt != ST_DONE);
      r_load_done <= (w_state_nxt == ST_DONE);
      r_load_err  <= (w_state_nxt == ST_ERR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count        <= '0;
      r_words_loaded <= '0;
      r_wr_idx       <= '0;
    end else begin
      if (w_clear) begin
        r_words_loaded <= '0;
        r_wr_idx       <= '0;
      end else if (w_mem_we) begin
        r_words_loaded <= w_words_inc;
        r_wr_idx       <= r_wr_idx + 1'b1;
      end
      if (w_accept && (r_state == ST_HDR0)) r_count[7:0]  <= ld_data;
      if (w_accept && (r_state == ST_HDR1)) r_count[15:8] <= ld_data;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_wr_idx] <= w_word;
  end

  assign w_word_addr  = addr >> 2;
  assign w_rd_idx     = addr[IDX_W+1:2];
  assign misaligned   = (addr[1:0] != 2'b00);
  assign out_of_range = (w_word_addr >= ADDR_WIDTH'(DEPTH_WORDS));
  assign rdata        = (r_cpu_hold || out_of_range) ? NOP_WORD : r_mem[w_rd_idx];

  assign ld_ready     = r_ld_ready;
  assign cpu_hold     = r_cpu_hold;
  assign load_done    = r_load_done;
  assign load_err     = r_load_err;
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: queued expectations checked by a negedge monitor.
module tb_imem_boot_loader;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        misaligned;
  logic        out_of_range;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  imem_boot_loader #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH_WORDS(DEPTH),
    .NOP_WORD   (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .addr        (addr),
    .rdata       (rdata),
    .misaligned  (misaligned),
    .out_of_range(out_of_range),
    .cpu_hold    (cpu_hold),
    .load_done   (load_done),
    .load_err    (load_err),
    .words_loaded(words_loaded)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
    logic        oor;
    logic        hold;
    logic        done;
    logic        err;
    logic        rdy;
    logic [15:0] words;
  } snap_t;

  typedef struct packed {
    logic        err;
    logic [15:0] words;
  } comp_t;

  snap_t       snap_q[$];
  string       name_q[$];
  comp_t       comp_q[$];
  logic [31:0] model_mem  [DEPTH];
  logic [31:0] stim_words [DEPTH];

  int   n_checks = 0;
  int   n_errors = 0;
  logic chk      = 1'b0;
  logic tmo_req  = 1'b0;
  logic fin_req  = 1'b0;
  int   gap_max  = 0;

  // Monitor: compares on snapshot strobes and on every load completion/error edge.
  initial begin : monitor
    snap_t       act;
    snap_t       exp;
    comp_t       c;
    string       nm;
    logic [19:0] got_c;
    logic [19:0] want_c;
    logic        prev_done;
    logic        prev_err;
    prev_done = 1'b0;
    prev_err  = 1'b0;
    forever begin
      @(negedge clk);
      act = {rdata, misaligned, out_of_range, cpu_hold, load_done, load_err, ld_ready, words_loaded};
      if (rst_n) begin
        if (chk) begin
          n_checks++;
          if (snap_q.size() == 0) begin
            n_errors++;
            $display("FAIL snapshot_underflow: got %h, no expectation queued", act);
          end else begin
            exp = snap_q.pop_front();
            nm  = name_q.pop_front();
            if (act !== exp) begin
              n_errors++;
              $display("FAIL %s: got %h, expected %h", nm, act, exp);
            end
          end
        end
        if ((load_done && !prev_done) || (load_err && !prev_err)) begin
          n_checks++;
          got_c = {cpu_hold, load_done, load_err, ld_ready, words_loaded};
          if (comp_q.size() == 0) begin
            n_errors++;
            $display("FAIL completion_unexpected: got %h, expected no completion", got_c);
          end else begin
            c      = comp_q.pop_front();
            want_c = {c.err, !c.err, c.err, 1'b0, c.words};
            if (got_c !== want_c) begin
              n_errors++;
              $display("FAIL completion: got %h, expected %h", got_c, want_c);
            end
          end
        end
        if (tmo_req) begin
          n_checks++;
          n_errors++;
          $display("FAIL timeout: got no response, expected handshake/completion within budget");
        end
        if (fin_req) begin
          n_checks++;
          if (comp_q.size() != 0 || snap_q.size() != 0) begin
            n_errors++;
            $display("FAIL leftover: got %0d completions and %0d snapshots pending, expected 0",
                     comp_q.size(), snap_q.size());
          end
        end
      end
      prev_done = load_done;
      prev_err  = load_err;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic raise_tmo();
    tmo_req = 1'b1;
    step();
    tmo_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    bit rdy;
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) step();
    ld_valid = 1'b1;
    ld_data  = b;
    ok       = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      rdy = ld_ready;
      step();
      ok = rdy;
    end
    ld_valid = 1'b0;
    if (!ok) raise_tmo();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] cnt);
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
  endtask

  task automatic push_comp(input logic err, input logic [15:0] words);
    comp_t c;
    c.err   = err;
    c.words = words;
    comp_q.push_back(c);
  endtask

  // Whole load from stim_words; the model records only words a valid count writes.
  task automatic full_load(input int unsigned cnt);
    pulse_start();
    if (cnt > DEPTH) push_comp(1'b1, 16'd0);
    else             push_comp(1'b0, 16'(cnt));
    send_hdr(16'(cnt));
    if (cnt >= 1 && cnt <= DEPTH) begin
      for (int i = 0; i < int'(cnt); i++) begin
        send_word(stim_words[i]);
        model_mem[i] = stim_words[i];
      end
    end
    if (!(load_done || load_err)) raise_tmo();
  endtask

  task automatic snap_state(input logic [31:0] a, input logic hold, input logic done,
                            input logic err, input logic rdy, input logic [15:0] words,
                            input string nm);
    snap_t e;
    e.oor   = ((a >> 2) >= DEPTH);
    e.mis   = (a[1:0] != 2'b00);
    e.rdata = (hold || e.oor) ? NOP : model_mem[4'(a >> 2)];
    e.hold  = hold;
    e.done  = done;
    e.err   = err;
    e.rdy   = rdy;
    e.words = words;
    addr    = a;
    snap_q.push_back(e);
    name_q.push_back(nm);
    chk = 1'b1;
    step();
    chk = 1'b0;
  endtask

  task automatic snap_done(input logic [31:0] a, input logic [15:0] words, input string nm);
    snap_state(a, 1'b0, 1'b1, 1'b0, 1'b0, words, nm);
  endtask

  initial begin : stimulus
    int unsigned cnt;
    rst_n      = 1'b0;
    load_start = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = 8'h00;
    addr       = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    snap_state(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, "reset_state");

    // Basic two-word load and fetch-port flags
    stim_words[0] = 32'h1234_5678;
    stim_words[1] = 32'hDEAD_BEEF;
    full_load(2);
    snap_done(32'd4, 16'd2, "basic_word1");
    snap_done(32'd0, 16'd2, "basic_word0");
    snap_done(32'(DEPTH * 4), 16'd2, "out_of_range");
    snap_done(32'd6, 16'd2, "misaligned");

    // Oversized headers, and bytes offered while in ERR
    full_load(DEPTH + 1);
    snap_state(32'd4, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, "err_fetch_nop");
    ld_valid = 1'b1;
    ld_data  = 8'hA5;
    repeat (3) step();
    ld_valid = 1'b0;
    snap_state(32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, "err_byte_ignored");
    full_load(32'hFFFF);
    snap_state(32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, "err_max_header");

    // Zero-length load leaves memory untouched
    full_load(0);
    snap_done(32'd0, 16'd0, "zero_len_mem0");
    snap_done(32'd4, 16'd0, "zero_len_mem1");

    // Fetch while loading, and load_start ignored mid-stream
    gap_max = 2;
    for (int i = 0; i < 3; i++) stim_words[i] = $urandom;
    pulse_start();
    push_comp(1'b0, 16'd3);
    send_hdr(16'd3);
    send_word(stim_words[0]);
    model_mem[0] = stim_words[0];
    send_byte(stim_words[1][7:0]);
    send_byte(stim_words[1][15:8]);
    snap_state(32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, "fetch_during_load");
    pulse_start();
    snap_state(32'd4, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, "start_ignored_in_data");
    send_byte(stim_words[1][23:16]);
    send_byte(stim_words[1][31:24]);
    model_mem[1] = stim_words[1];
    send_word(stim_words[2]);
    model_mem[2] = stim_words[2];
    if (!(load_done || load_err)) raise_tmo();
    for (int i = 0; i < 3; i++) snap_done(32'(i * 4), 16'd3, $sformatf("gapped_word%0d", i));

    // Reset in the middle of a load keeps already written words
    gap_max = 0;
    stim_words[0] = $urandom;
    stim_words[1] = $urandom;
    pulse_start();
    send_hdr(16'd2);
    send_word(stim_words[0]);
    model_mem[0] = stim_words[0];
    send_byte(stim_words[1][7:0]);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    snap_state(32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, "after_mid_reset");
    full_load(0);
    snap_done(32'd0, 16'd0, "reset_kept_mem0");
    snap_done(32'd4, 16'd0, "partial_not_written");
    stim_words[0] = $urandom;
    stim_words[1] = $urandom;
    full_load(2);
    snap_done(32'd0, 16'd2, "reload_word0");
    snap_done(32'd4, 16'd2, "reload_word1");

    // Random loads with gaps, first one filling the whole array
    gap_max = 3;
    for (int r = 0; r < 4; r++) begin
      cnt = (r == 0) ? DEPTH : $urandom_range(1, DEPTH);
      for (int i = 0; i < int'(cnt); i++) stim_words[i] = $urandom;
      full_load(cnt);
      for (int i = 0; i < int'(cnt); i++)
        snap_done(32'(i * 4) + 32'($urandom_range(0, 3)), 16'(cnt),
                  $sformatf("rand%0d_word%0d", r, i));
    end

    fin_req = 1'b1;
    step();
    fin_req = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
